// File: rtl/algo_1r1w_ingress_ctl.sv
// rtl/algo_1r1w_ingress_ctl.sv - client ingress stage: write queue, read register, refresh pulse, RAW stall
module algo_1r1w_ingress_ctl #(
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int WQDEPTH = 4,
    parameter int BITWQ   = 2,
    parameter int REFRESH = 1,
    parameter int REFFREQ = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cl_write,
    input  logic [BITADDR-1:0] cl_wr_adr,
    input  logic [WIDTH-1:0]   cl_din,
    output logic               cl_wr_rdy,
    input  logic               cl_read,
    input  logic [BITADDR-1:0] cl_rd_adr,
    output logic               cl_rd_rdy,
    input  logic               ready,
    output logic               refr,
    output logic               write,
    output logic [BITADDR-1:0] wr_adr,
    output logic [WIDTH-1:0]   din,
    output logic               read,
    output logic [BITADDR-1:0] rd_adr
);

    localparam int CNTW = (REFFREQ > 2) ? $clog2(REFFREQ) : 1;
    localparam logic [CNTW-1:0]  CNTLAST = CNTW'(REFFREQ - 1);
    localparam logic [BITWQ:0]   QFULL   = (BITWQ + 1)'(WQDEPTH);

    typedef enum logic {INIT, RUN} stateT;

    stateT              state;
    logic [BITADDR-1:0] qAdr [WQDEPTH];
    logic [WIDTH-1:0]   qDat [WQDEPTH];
    logic [BITWQ-1:0]   wrPtr;
    logic [BITWQ-1:0]   rdPtr;
    logic [BITWQ:0]     occ;
    logic [CNTW-1:0]    cnt;

    logic               isRun;
    logic               qEmpty;
    logic               qFull;
    logic               refrNxt;
    logic               push;
    logic               pop;
    logic               rdAccept;
    logic               hit;
    logic [BITWQ-1:0]   slotOff;

    assign isRun     = (state == RUN);
    assign qEmpty    = (occ == '0);
    assign qFull     = (occ == QFULL);
    assign refrNxt   = (REFRESH != 0) && isRun && (cnt == CNTLAST);
    // Refresh wins the slot: a pop is held back so write and refr never coincide.
    assign pop       = isRun && !qEmpty && !refrNxt;
    assign cl_wr_rdy = isRun && !qFull;
    assign push      = cl_write && cl_wr_rdy;
    assign cl_rd_rdy = isRun && !hit;
    assign rdAccept  = cl_read && cl_rd_rdy;

    // Read hazard: compare against every live queue slot, including the one popping now.
    always_comb begin
        hit     = 1'b0;
        slotOff = '0;
        for (int i = 0; i < WQDEPTH; i++) begin
            slotOff = BITWQ'(i) - rdPtr;
            if (({1'b0, slotOff} < occ) && (qAdr[i] == cl_rd_adr)) begin
                hit = 1'b1;
            end
        end
    end

    // Queue storage; no reset needed because occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            qAdr[wrPtr] <= cl_wr_adr;
            qDat[wrPtr] <= cl_din;
        end
    end

    // Control FSM, queue pointers, refresh counter and registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT;
            wrPtr  <= '0;
            rdPtr  <= '0;
            occ    <= '0;
            cnt    <= '0;
            refr   <= 1'b0;
            write  <= 1'b0;
            wr_adr <= '0;
            din    <= '0;
            read   <= 1'b0;
            rd_adr <= '0;
        end else begin
            if (state == INIT && ready) begin
                state <= RUN;
            end
            if (isRun) begin
                cnt <= (cnt == CNTLAST) ? '0 : cnt + 1'b1;
            end
            refr  <= refrNxt;
            write <= pop;
            if (pop) begin
                wr_adr <= qAdr[rdPtr];
                din    <= qDat[rdPtr];
                rdPtr  <= rdPtr + 1'b1;
            end
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            read <= rdAccept;
            if (rdAccept) begin
                rd_adr <= cl_rd_adr;
            end
        end
    end

    // Structural invariants of the queue and the memory-side slot sharing.
    a_noPushFull:  assert property (@(posedge clk) disable iff (rst) !(push && qFull));
    a_noPopEmpty:  assert property (@(posedge clk) disable iff (rst) !(pop && qEmpty));
    a_noWriteRefr: assert property (@(posedge clk) disable iff (rst) !(write && refr));

endmodule

// File: tb/tb_algo_1r1w_ingress_ctl.sv
// tb/tb_algo_1r1w_ingress_ctl.sv - randomized self-checking bench with queue-based reference model
module tb_algo_1r1w_ingress_ctl;

    localparam int WIDTH   = 32;
    localparam int BITADDR = 13;
    localparam int WQDEPTH = 4;
    localparam int BITWQ   = 2;
    localparam int REFFREQ = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               cl_write;
    logic [BITADDR-1:0] cl_wr_adr;
    logic [WIDTH-1:0]   cl_din;
    logic               cl_wr_rdy;
    logic               cl_read;
    logic [BITADDR-1:0] cl_rd_adr;
    logic               cl_rd_rdy;
    logic               ready;
    logic               refr;
    logic               write;
    logic [BITADDR-1:0] wr_adr;
    logic [WIDTH-1:0]   din;
    logic               read;
    logic [BITADDR-1:0] rd_adr;

    logic               z0WrRdy, z0RdRdy, z0Refr, z0Write, z0Read;
    logic [BITADDR-1:0] z0WrAdr, z0RdAdr;
    logic [WIDTH-1:0]   z0Din;

    always #5 clk = ~clk;

    algo_1r1w_ingress_ctl #(
        .WIDTH(WIDTH), .BITADDR(BITADDR), .WQDEPTH(WQDEPTH), .BITWQ(BITWQ),
        .REFRESH(1), .REFFREQ(REFFREQ)
    ) dut (
        .clk(clk), .rst(rst),
        .cl_write(cl_write), .cl_wr_adr(cl_wr_adr), .cl_din(cl_din), .cl_wr_rdy(cl_wr_rdy),
        .cl_read(cl_read), .cl_rd_adr(cl_rd_adr), .cl_rd_rdy(cl_rd_rdy),
        .ready(ready), .refr(refr),
        .write(write), .wr_adr(wr_adr), .din(din),
        .read(read), .rd_adr(rd_adr)
    );

    algo_1r1w_ingress_ctl #(
        .WIDTH(WIDTH), .BITADDR(BITADDR), .WQDEPTH(WQDEPTH), .BITWQ(BITWQ),
        .REFRESH(0), .REFFREQ(REFFREQ)
    ) dutNoRefr (
        .clk(clk), .rst(rst),
        .cl_write(cl_write), .cl_wr_adr(cl_wr_adr), .cl_din(cl_din), .cl_wr_rdy(z0WrRdy),
        .cl_read(cl_read), .cl_rd_adr(cl_rd_adr), .cl_rd_rdy(z0RdRdy),
        .ready(ready), .refr(z0Refr),
        .write(z0Write), .wr_adr(z0WrAdr), .din(z0Din),
        .read(z0Read), .rd_adr(z0RdAdr)
    );

    int nChecks = 0;
    int nFail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: client-order queue of pending writes plus RUN-cycle count.
    typedef struct {
        logic [BITADDR-1:0] adr;
        logic [WIDTH-1:0]   dat;
    } entT;

    entT                mq[$];
    entT                ent;
    bit                 mValid = 0;
    bit                 mRun;
    int                 tRun;
    bit                 eRefr, eWrite, eRead;
    logic [BITADDR-1:0] eWrAdr, eRdAdr;
    logic [WIDTH-1:0]   eDin;
    bit                 expWrRdy, expRdRdy, hitM, refrNow, popNow;

    always @(negedge clk) begin
        if (mValid) begin
            expWrRdy = mRun && (mq.size() < WQDEPTH);
            hitM = 0;
            foreach (mq[i]) if (mq[i].adr == cl_rd_adr) hitM = 1;
            expRdRdy = mRun && !hitM;
            chk("cl_wr_rdy", cl_wr_rdy, expWrRdy);
            chk("cl_rd_rdy", cl_rd_rdy, expRdRdy);
            chk("refr", refr, eRefr);
            chk("write", write, eWrite);
            chk("wr_adr", wr_adr, eWrAdr);
            chk("din", din, eDin);
            chk("read", read, eRead);
            chk("rd_adr", rd_adr, eRdAdr);
            chk("refr_disabled", z0Refr, 0);
        end
        if (rst) begin
            mq.delete();
            mValid = 1; mRun = 0; tRun = 0;
            eRefr = 0; eWrite = 0; eRead = 0;
            eWrAdr = '0; eDin = '0; eRdAdr = '0;
        end else if (mValid) begin
            refrNow = mRun && (tRun % REFFREQ == REFFREQ - 1);
            popNow  = mRun && (mq.size() != 0) && !refrNow;
            eRefr   = refrNow;
            eWrite  = popNow;
            if (popNow) begin
                ent    = mq.pop_front();
                eWrAdr = ent.adr;
                eDin   = ent.dat;
            end
            if (cl_write && expWrRdy) mq.push_back('{cl_wr_adr, cl_din});
            eRead = cl_read && expRdRdy;
            if (eRead) eRdAdr = cl_rd_adr;
            if (mRun) tRun++;
            else if (ready) mRun = 1;
        end
    end

    bit wSeen55 = 0;
    bit watchT6 = 0;
    bit badT6   = 0;

    always @(posedge clk) begin
        if (write && wr_adr == 13'h055) wSeen55 = 1;
        if (watchT6 && write && wr_adr >= 13'h100 && wr_adr <= 13'h102) badT6 = 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    bit sawFull;
    int k;

    initial begin
        rst = 1; ready = 0;
        cl_write = 0; cl_wr_adr = '0; cl_din = '0;
        cl_read = 0; cl_rd_adr = '0;
        repeat (3) cyc();
        chk("T1 reset outputs", {refr, write, read, cl_wr_rdy, cl_rd_rdy}, 0);
        chk("T1 reset addr/data", {wr_adr, din, rd_adr}, 0);
        rst = 0;
        repeat (10) begin
            cyc();
            chk("T1 held off", {cl_wr_rdy, cl_rd_rdy, refr}, 0);
        end

        // T2: ready in cycle R, first RUN cycle R+1 at refresh count 0.
        ready = 1;
        cyc();
        cl_write = 1; cl_wr_adr = 13'd0; cl_din = 32'hA0;
        #1 chk("T2 wr_rdy in RUN", cl_wr_rdy, 1);
        cyc();
        cl_wr_adr = 13'd1; cl_din = 32'hA1;
        cyc();
        chk("T2 first write", {write, wr_adr, din}, {1'b1, 13'd0, 32'hA0});
        cl_wr_adr = 13'd2; cl_din = 32'hA2;
        cyc();
        cl_wr_adr = 13'd3; cl_din = 32'hA3;
        cyc();
        cl_write = 0;
        cyc();
        chk("T2 last write", {write, wr_adr, din}, {1'b1, 13'd3, 32'hA3});
        cyc();
        chk("T3 first refr", {refr, write}, 2'b10);
        repeat (6) cyc();
        chk("T3 second refr", refr, 1);
        cyc();
        chk("T3 refr one cycle", refr, 0);

        // T3/T4: keep the queue busy so refresh slots back it up until full.
        sawFull = 0;
        cl_write = 1;
        repeat (60) begin
            cl_wr_adr = BITADDR'($urandom_range(0, 15));
            cl_din    = $urandom;
            #1 if (!cl_wr_rdy) sawFull = 1;
            cyc();
        end
        chk("T4 queue reached full", sawFull, 1);
        cl_write = 0;
        repeat (8) cyc();

        // Random traffic with address collisions; ready toggles are ignored in RUN.
        repeat (300) begin
            cl_write  = $urandom_range(0, 1);
            cl_wr_adr = BITADDR'($urandom_range(0, 7));
            cl_din    = $urandom;
            cl_read   = $urandom_range(0, 1);
            cl_rd_adr = BITADDR'($urandom_range(0, 7));
            ready     = $urandom_range(0, 1);
            cyc();
        end
        cl_write = 0; cl_read = 0; ready = 1;
        repeat (8) cyc();

        // T5: read-after-write stall.
        wSeen55 = 0;
        cl_write = 1; cl_wr_adr = 13'h055; cl_din = 32'h1234;
        cyc();
        cl_write = 0; cl_read = 1; cl_rd_adr = 13'h055;
        #1 chk("T5 read stalled", cl_rd_rdy, 0);
        k = 0;
        do begin
            cyc();
            k++;
        end while (!cl_rd_rdy && k < 10);
        chk("T5 read eventually accepted", cl_rd_rdy, 1);
        cyc();
        cl_read = 0;
        chk("T5 read issued", {read, rd_adr}, {1'b1, 13'h055});
        chk("T5 write issued first", wSeen55, 1);
        repeat (4) cyc();
        cl_write = 1; cl_wr_adr = 13'h055; cl_din = 32'h5678;
        cyc();
        cl_write = 0; cl_read = 1; cl_rd_adr = 13'h056;
        #1 chk("T5 other addr not stalled", cl_rd_rdy, 1);
        cyc();
        cl_read = 0;
        chk("T5 other addr read", {read, rd_adr}, {1'b1, 13'h056});
        repeat (4) cyc();

        // T6: reset while writes are in flight.
        cl_write = 1;
        for (int i = 0; i < 3; i++) begin
            cl_wr_adr = BITADDR'(13'h100 + i);
            cl_din    = 32'hC0 + i;
            cyc();
        end
        cl_write = 0; rst = 1; ready = 0;
        cyc();
        rst = 0;
        watchT6 = 1;
        #1 chk("T6 back in INIT", {cl_wr_rdy, cl_rd_rdy, write, refr}, 0);
        cyc();
        ready = 1;
        repeat (20) cyc();
        chk("T6 no flushed write", badT6, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
